// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the count-width helper.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit counter is wide enough to hold WIDTH-1 with one spare bit.
   function automatic int cnt_w(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor cell: d = x - y - bin.
// Ports: x, y, bin in; d difference, bo borrow out.
module full_subtractor_bit (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bin;
   assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor diff = a - b, LSB first, one bit per clock.
// Ports: clk, rst_n; in_valid/in_ready with a, b; out_valid/out_ready
// with diff, bout (unsigned borrow) and ovf (signed overflow).
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;

   logic fs_d;
   logic fs_bo;
   logic last;

   full_subtractor_bit u_fs (
      .x   (a_sh_q[0]),
      .y   (b_sh_q[0]),
      .bin (brw_q),
      .d   (fs_d),
      .bo  (fs_bo)
   );

   assign last = (cnt_q == LAST);

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (in_valid) state_d = RUN;
         RUN:  if (last) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs, decoded from state only
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // Datapath next values
   always_comb begin
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               brw_d   = 1'b0;
               cnt_d   = '0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
            end
         end
         RUN: begin
            a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            res_d  = {fs_d, res_q[WIDTH-1:1]};
            brw_d  = fs_bo;
            cnt_d  = cnt_q + CW'(1);
            if (last) begin
               bout_d = fs_bo;
               // Overflow: operand signs differ and result sign
               // differs from the minuend sign.
               ovf_d  = (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
            end
         end
         DONE: ;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
      end else begin
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
      end
   end

   assign diff = res_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4).
// Directed cases plus random ops against an arithmetic model.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int checks = 0;
   int failures = 0;
   int pb = 0;
   int po = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic void model(input int ua, input int ub,
                                 output int md, output int mb,
                                 output int mo);
      int sa;
      int sb;
      int r;
      md = (ua - ub + (1 << W)) % (1 << W);
      mb = (ua < ub) ? 1 : 0;
      sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
      sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
      r  = sa - sb;
      mo = (r > (1 << (W - 1)) - 1 || r < -(1 << (W - 1))) ? 1 : 0;
   endfunction

   // Issue one op, wait for result, hold out_ready low for 'hold'
   // cycles, then consume. Returns measured latency in edges.
   task automatic do_op(input int ta, input int tb_, input int hold,
                        output int lat);
      int md;
      int mb;
      int mo;
      model(ta, tb_, md, mb, mo);
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      a = W'(ta);
      b = W'(tb_);
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat <= 3 * W) begin
         chk("in_ready_run", in_ready, 0);
         chk("bout_held", bout, pb);
         chk("ovf_held", ovf, po);
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", lat, W);
      chk("out_valid", out_valid, 1);
      chk("diff", diff, md);
      chk("bout", bout, mb);
      chk("ovf", ovf, mo);
      chk("in_ready_done", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         if (i == 0) begin
            a = 4'd1;
            b = 4'd1;
            in_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk("bp_valid", out_valid, 1);
         chk("bp_diff", diff, md);
         chk("bp_bout", bout, mb);
         chk("bp_ovf", ovf, mo);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("consumed_ready", in_ready, 1);
      chk("consumed_valid", out_valid, 0);
      pb = mb;
      po = mo;
   endtask

   int lat;
   int ii;
   int md;
   int mb;
   int mo;
   int ra;
   int rb;

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(9, 3, 0, lat);
      do_op(3, 9, 0, lat);
      do_op(0, 1, 0, lat);
      do_op(8, 1, 0, lat);
      do_op(0, 0, 0, lat);
      do_op(6, 11, 5, lat);

      // Abort mid-run with async reset.
      @(negedge clk);
      a = 4'd7;
      b = 4'd2;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_diff", diff, 0);
      chk("abort_bout", bout, 0);
      chk("abort_ovf", ovf, 0);
      chk("abort_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      pb = 0;
      po = 0;
      do_op(5, 5, 0, lat);

      // Back-to-back with out_ready held high.
      @(negedge clk);
      a = 4'd15;
      b = 4'd15;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat <= 3 * W) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("b2b_lat1", lat, W);
      chk("b2b_diff1", diff, 0);
      chk("b2b_bout1", bout, 0);
      @(posedge clk);
      #1;
      chk("b2b_ready", in_ready, 1);
      a = 4'd1;
      b = 4'd2;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ii = lat + 2;
      chk("b2b_ii", ii, W + 2);
      lat = 0;
      while (!out_valid && lat <= 3 * W) begin
         @(posedge clk);
         #1;
         lat++;
      end
      model(1, 2, md, mb, mo);
      chk("b2b_lat2", lat, W);
      chk("b2b_diff2", diff, md);
      chk("b2b_bout2", bout, mb);
      chk("b2b_ovf2", ovf, mo);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      pb = mb;
      po = mo;

      for (int k = 0; k < 40; k++) begin
         ra = int'($urandom_range(0, (1 << W) - 1));
         rb = int'($urandom_range(0, (1 << W) - 1));
         do_op(ra, rb, int'($urandom_range(0, 3)), lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
